// File: rtl/rst_seq_gen.sv
// Reset sequencer: syncs MMCM locked, waits for a stable lock, then releases a sync-deassert domain reset.
// Latency: rst_out falls SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES edges after locked is first sampled high.
// No backpressure; define RST_SEQ_GEN_TIMEOUT_EN to enable the sticky lock-wait timeout flag.
module rst_seq_gen #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic sw_rst_req,
    output logic rst_out,
    output logic ready,
    output logic lock_lost,
    output logic lock_timeout
);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        (64'(STABLE_CYCLES) >> CNT_WIDTH) != 64'd0 ||
        (64'(HOLD_CYCLES) >> CNT_WIDTH) != 64'd0 ||
        (64'(TIMEOUT_CYCLES) >> CNT_WIDTH) != 64'd0) begin : g_param_check
        $error("rst_seq_gen: illegal parameter combination");
    end

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   lost_set;

    // Only locked_s may be used downstream; raw locked is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_GEN_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
    logic timeout_set;
    logic timeout_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost_set = 1'b0;
`ifdef RST_SEQ_GEN_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
`ifdef RST_SEQ_GEN_TIMEOUT_EN
                    // Saturate so a very long wait never wraps back into a fresh count.
                    if (cnt_q != TIMEOUT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (cnt_q == TIMEOUT_LAST) begin
                        timeout_set = 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss wins over a simultaneous software request.
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    lost_set = 1'b1;
                end else if (sw_rst_req) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out   <= 1'b1;
            lock_lost <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_out <= (state_d != RUN);
            if (lost_set) begin
                lock_lost <= 1'b1;
            end
        end
    end

    assign ready = ~rst_out;

`ifdef RST_SEQ_GEN_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end
    end

    assign lock_timeout = timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench for rst_seq_gen: directed scenarios plus randomized locked/sw_rst_req traffic.
module tb_rst_seq_gen;

    localparam int SYNC  = 2;
    localparam int STAB  = 8;
    localparam int HOLDC = 4;
    localparam int TMO   = 20;
    localparam int REL   = 1 + STAB + HOLDC;
`ifdef RST_SEQ_GEN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b0;
    logic sw_rst_req = 1'b0;
    logic rst_out, ready, lock_lost, lock_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: release once locked_s has been seen high on REL consecutive edges.
    logic hist [SYNC];
    int   streak;
    int   wcnt;
    logic m_lost;
    logic m_tmo;

    rst_seq_gen #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .HOLD_CYCLES   (HOLDC),
        .CNT_WIDTH     (16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .sw_rst_req  (sw_rst_req),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
        streak = 0;
        wcnt   = 0;
        m_lost = 1'b0;
        m_tmo  = 1'b0;
    endfunction

    function automatic void model_edge(input logic lk, input logic sw);
        logic ls;
        bit   released;
        ls       = hist[SYNC-1];
        released = (streak >= REL);
        if (ls == 1'b0) begin
            if (released) m_lost = 1'b1;
            wcnt   = (streak == 0) ? wcnt + 1 : 0;
            streak = 0;
            if (TMO_EN && wcnt >= TMO) m_tmo = 1'b1;
        end else begin
            wcnt = 0;
            if (released && sw) streak = 1 + STAB;
            else if (!released) streak++;
        end
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = lk;
    endfunction

    task automatic tick(input logic lk, input logic sw);
        locked     = lk;
        sw_rst_req = sw;
        @(posedge clk);
        model_edge(lk, sw);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        locked     = 1'b0;
        sw_rst_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic exp;
        rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
        n_tests++; if (lock_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_lock_timeout: got %b want 0", lock_timeout); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int e = 0; e <= 14; e++) begin
            tick(1'b1, 1'b0);
            exp = (e < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL powerup_rst_out edge %0d: got %b want %b", e, rst_out, exp); end
            n_tests++; if (ready !== ~exp) begin n_fail++; $display("FAIL powerup_ready edge %0d: got %b want %b", e, ready, ~exp); end
        end
        n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL powerup_lock_lost: got %b want 0", lock_lost); end
    endtask

    task automatic test_glitch();
        logic exp;
        do_reset();
        for (int e = 0; e <= 24; e++) begin
            tick((e == 6 || e == 7) ? 1'b0 : 1'b1, 1'b0);
            exp = (e < 22);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL glitch_rst_out edge %0d: got %b want %b", e, rst_out, exp); end
            n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL glitch_lock_lost edge %0d: got %b want 0", e, lock_lost); end
        end
    endtask

    task automatic test_lock_loss();
        logic exp;
        for (int e = 0; e <= 5; e++) begin
            tick(1'b0, 1'b0);
            exp = (e >= 2);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL lossrun_rst_out edge %0d: got %b want %b", e, rst_out, exp); end
            n_tests++; if (lock_lost !== exp) begin n_fail++; $display("FAIL lossrun_lock_lost edge %0d: got %b want %b", e, lock_lost, exp); end
        end
        for (int r = 0; r <= 15; r++) begin
            tick(1'b1, 1'b0);
            exp = (r < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL relock_rst_out edge %0d: got %b want %b", r, rst_out, exp); end
            n_tests++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL relock_lock_lost edge %0d: got %b want 1", r, lock_lost); end
        end
    endtask

    task automatic test_async_reset();
        logic exp;
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL async_run_rst_out: got %b want 1", rst_out); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_run_ready: got %b want 0", ready); end
        n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL async_run_lock_lost: got %b want 0", lock_lost); end
        do_reset();
        for (int e = 0; e <= 11; e++) tick(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL async_hold_rst_out: got %b want 1", rst_out); end
        n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL async_hold_lock_lost: got %b want 0", lock_lost); end
        n_tests++; if (lock_timeout !== 1'b0) begin n_fail++; $display("FAIL async_hold_lock_timeout: got %b want 0", lock_timeout); end
        do_reset();
        for (int e = 0; e <= 14; e++) begin
            tick(1'b1, 1'b0);
            exp = (e < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL async_restart_rst_out edge %0d: got %b want %b", e, rst_out, exp); end
        end
    endtask

    task automatic test_sw_reset();
        logic exp;
        do_reset();
        // The request during HOLD must be ignored.
        for (int e = 0; e <= 14; e++) begin
            tick(1'b1, (e == 12) ? 1'b1 : 1'b0);
            exp = (e < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL sw_ignored_rst_out edge %0d: got %b want %b", e, rst_out, exp); end
        end
        tick(1'b1, 1'b1);
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL sw_pulse_start: got %b want 1", rst_out); end
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 1'b0);
            exp = (k < 4);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL sw_pulse cycle %0d: got %b want %b", k, rst_out, exp); end
        end
        n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL sw_lock_lost: got %b want 0", lock_lost); end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_tests++; if (rst_out !== 1'b0) begin n_fail++; $display("FAIL sw_prefall_rst_out: got %b want 0", rst_out); end
        tick(1'b0, 1'b1);
        n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL sw_vs_loss_rst_out: got %b want 1", rst_out); end
        n_tests++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL sw_vs_loss_lock_lost: got %b want 1", lock_lost); end
        for (int r = 0; r <= 14; r++) begin
            tick(1'b1, 1'b0);
            exp = (r < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL sw_vs_loss_relock edge %0d: got %b want %b", r, rst_out, exp); end
        end
    endtask

    task automatic test_timeout();
        logic exp_t, exp;
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            tick(1'b0, 1'b0);
            exp_t = TMO_EN && (e >= TMO);
            n_tests++; if (lock_timeout !== exp_t) begin n_fail++; $display("FAIL timeout_flag edge %0d: got %b want %b", e, lock_timeout, exp_t); end
            n_tests++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL timeout_rst_out edge %0d: got %b want 1", e, rst_out); end
        end
        for (int r = 0; r <= 14; r++) begin
            tick(1'b1, 1'b0);
            exp = (r < 14);
            n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL timeout_relock_rst_out edge %0d: got %b want %b", r, rst_out, exp); end
            n_tests++; if (lock_timeout !== TMO_EN) begin n_fail++; $display("FAIL timeout_sticky edge %0d: got %b want %b", r, lock_timeout, TMO_EN); end
        end
    endtask

    task automatic test_random();
        logic lk, sw, exp;
        int   len;
        int   cyc;
        do_reset();
        cyc = 0;
        while (cyc < 3000) begin
            lk  = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
            for (int i = 0; i < len; i++) begin
                sw = ($urandom_range(0, 15) == 0);
                tick(lk, sw);
                cyc++;
                exp = (streak < REL);
                n_tests++; if (rst_out !== exp) begin n_fail++; $display("FAIL rand_rst_out cycle %0d: got %b want %b", cyc, rst_out, exp); end
                n_tests++; if (ready !== ~exp) begin n_fail++; $display("FAIL rand_ready cycle %0d: got %b want %b", cyc, ready, ~exp); end
                n_tests++; if (lock_lost !== m_lost) begin n_fail++; $display("FAIL rand_lock_lost cycle %0d: got %b want %b", cyc, lock_lost, m_lost); end
                n_tests++; if (lock_timeout !== m_tmo) begin n_fail++; $display("FAIL rand_lock_timeout cycle %0d: got %b want %b", cyc, lock_timeout, m_tmo); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_lock_loss();
        test_async_reset();
        test_sw_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
